// File: rtl/dct2d_seq_if.sv
// Row-in / column-out handshake bundle for the 2-D DCT sequencer.
// The slave side is the sequencer; the master side is the row source
// together with the downstream column sink.
interface dct2d_seq_if #(
  parameter int N = 16
);
  logic           in_valid;
  logic           in_ready;
  logic [8*N-1:0] in_row;
  logic           out_valid;
  logic           out_ready;
  logic [8*N-1:0] out_col;
  logic           out_last;

  modport master (
    output in_valid, in_row, out_ready,
    input  in_ready, out_valid, out_col, out_last
  );

  modport slave (
    input  in_valid, in_row, out_ready,
    output in_ready, out_valid, out_col, out_last
  );
endinterface

// File: rtl/dct2d_seq.sv
// 8x8 2-D DCT sequencer around one shared combinational dct1d.
// Rows pass through dct1d into a transpose buffer; buffer columns then pass
// through the same dct1d into a registered output stage.
//
//   state | meaning
//   LOAD  | accept rows, dct_in = in_row, write dct_out into row_buf[row_cnt]
//   COL   | dct_in = column col_cnt of row_buf, feed the output register
module dct2d_seq #(
  parameter int N = 16
) (
  input  logic           clk,
  input  logic           reset_n,
  dct2d_seq_if.slave     bus,
  output logic [8*N-1:0] dct_in,
  input  logic [8*N-1:0] dct_out,
  output logic           busy
);

  typedef enum logic {
    LOAD = 1'b0,
    COL  = 1'b1
  } state_t;

  state_t         state, state_nxt;
  logic [2:0]     row_cnt, row_cnt_nxt;
  logic [2:0]     col_cnt, col_cnt_nxt;
  logic           row_acc;
  logic           out_load;

  // Transpose buffer: row_buf[r][c]; deliberately left without reset.
  logic [N-1:0]   row_buf [8][8];

  logic           out_valid_q;
  logic           out_last_q;
  logic [8*N-1:0] out_col_q;

  // Next-state and handshake decode for the LOAD/COL sequencer.
  always_comb begin
    state_nxt   = state;
    row_cnt_nxt = row_cnt;
    col_cnt_nxt = col_cnt;
    row_acc     = 1'b0;
    out_load    = 1'b0;
    case (state)
      LOAD: begin
        row_acc = bus.in_valid;
        if (row_acc) begin
          row_cnt_nxt = row_cnt + 3'd1;
          if (row_cnt == 3'd7) state_nxt = COL;
        end
      end
      COL: begin
        // The output register is free when empty or being drained this cycle.
        out_load = !out_valid_q || bus.out_ready;
        if (out_load) begin
          col_cnt_nxt = col_cnt + 3'd1;
          if (col_cnt == 3'd7) state_nxt = LOAD;
        end
      end
      default: state_nxt = LOAD;
    endcase
  end

  // State and counter registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state   <= LOAD;
      row_cnt <= 3'd0;
      col_cnt <= 3'd0;
    end else begin
      state   <= state_nxt;
      row_cnt <= row_cnt_nxt;
      col_cnt <= col_cnt_nxt;
    end
  end

  // Operand mux for the shared dct1d: the incoming row, or one buffer column.
  always_comb begin
    dct_in = bus.in_row;
    if (state == COL) begin
      for (int k = 0; k < 8; k++) begin
        dct_in[(7-k)*N +: N] = row_buf[k][col_cnt];
      end
    end
  end

  // Row-pass result lands in the buffer row addressed by row_cnt.
  always_ff @(posedge clk) begin
    if (row_acc) begin
      for (int k = 0; k < 8; k++) begin
        row_buf[row_cnt][k] <= dct_out[(7-k)*N +: N];
      end
    end
  end

  // Output register: load a new column, or drop valid once the sink takes it.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      out_valid_q <= 1'b0;
      out_last_q  <= 1'b0;
      out_col_q   <= '0;
    end else if (out_load) begin
      out_valid_q <= 1'b1;
      out_last_q  <= (col_cnt == 3'd7);
      out_col_q   <= dct_out;
    end else if (out_valid_q && bus.out_ready) begin
      out_valid_q <= 1'b0;
      out_last_q  <= 1'b0;
    end
  end

  assign bus.in_ready  = (state == LOAD);
  assign bus.out_valid = out_valid_q;
  assign bus.out_last  = out_last_q;
  assign bus.out_col   = out_col_q;
  assign busy          = (state == COL);

endmodule
